// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver: hex decode, blank/blink/dp per digit,
// anti-ghosting dead time, and frame-boundary double buffering of the displayed value.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 2,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

  // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRM_W-1:0]      frm_cnt_q, frm_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  pend_q, pend_d;
  logic [DW-1:0]         stg_dig_q, stg_dig_d, dsp_dig_q, dsp_dig_d;
  logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d, dsp_dp_q, dsp_dp_d;
  logic [NUM_DIGITS-1:0] stg_blank_q, stg_blank_d, dsp_blank_q, dsp_blank_d;
  logic [NUM_DIGITS-1:0] stg_blink_q, stg_blink_d, dsp_blink_q, dsp_blink_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  slot_wrap_s, frame_wrap_s;

  // Scan counters, blink timebase and staging/display buffering.
  always_comb begin
    div_cnt_d     = div_cnt_q;
    idx_d         = idx_q;
    frm_cnt_d     = frm_cnt_q;
    blink_phase_d = blink_phase_q;
    pend_d        = pend_q;
    stg_dig_d     = stg_dig_q;
    stg_dp_d      = stg_dp_q;
    stg_blank_d   = stg_blank_q;
    stg_blink_d   = stg_blink_q;
    dsp_dig_d     = dsp_dig_q;
    dsp_dp_d      = dsp_dp_q;
    dsp_blank_d   = dsp_blank_q;
    dsp_blink_d   = dsp_blink_q;
    slot_wrap_s   = (div_cnt_q == DIV_LAST);
    frame_wrap_s  = slot_wrap_s && (idx_q == IDX_LAST);
    frame_tick_d  = frame_wrap_s;

    if (slot_wrap_s) begin
      div_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    if (load) begin
      stg_dig_d   = digits_in;
      stg_dp_d    = dp_in;
      stg_blank_d = blank_in;
      stg_blink_d = blink_in;
    end else begin
      stg_dig_d   = stg_dig_q;
    end

    // A load landing on the wrap cycle bypasses staging so it shows this frame.
    if (frame_wrap_s) begin
      if (frm_cnt_q == FRM_LAST) begin
        frm_cnt_d     = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frm_cnt_d     = frm_cnt_q + 1'b1;
      end
      pend_d = 1'b0;
      if (load) begin
        dsp_dig_d   = digits_in;
        dsp_dp_d    = dp_in;
        dsp_blank_d = blank_in;
        dsp_blink_d = blink_in;
      end else if (pend_q) begin
        dsp_dig_d   = stg_dig_q;
        dsp_dp_d    = stg_dp_q;
        dsp_blank_d = stg_blank_q;
        dsp_blink_d = stg_blink_q;
      end else begin
        dsp_dig_d   = dsp_dig_q;
      end
    end else if (load) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Pin values for the current slot; registered below.
  always_comb begin
    logic dark_s;
    logic dead_s;
    dark_s = dsp_blank_q[idx_q] | (dsp_blink_q[idx_q] & blink_phase_q);
    dead_s = (int'(div_cnt_q) < DEAD_CYC);
    an_d   = '1;
    seg_d  = 7'b1111111;
    dp_d   = 1'b1;
    if (!dead_s && !dark_s) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = hex_to_seg(dsp_dig_q[4*int'(idx_q) +: 4]);
      dp_d  = ~dsp_dp_q[idx_q];
    end else begin
      an_d  = '1;
    end
  end

  // State and output registers; the display powers up blanked.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      frm_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
      pend_q        <= 1'b0;
      stg_dig_q     <= '0;
      stg_dp_q      <= '0;
      stg_blank_q   <= '1;
      stg_blink_q   <= '0;
      dsp_dig_q     <= '0;
      dsp_dp_q      <= '0;
      dsp_blank_q   <= '1;
      dsp_blink_q   <= '0;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      frm_cnt_q     <= frm_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_q        <= pend_d;
      stg_dig_q     <= stg_dig_d;
      stg_dp_q      <= stg_dp_d;
      stg_blank_q   <= stg_blank_d;
      stg_blink_q   <= stg_blink_d;
      dsp_dig_q     <= dsp_dig_d;
      dsp_dp_q      <= dsp_dp_d;
      dsp_blank_q   <= dsp_blank_d;
      dsp_blink_q   <= dsp_blink_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYC=1, BLINK_DIV=2.
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [3:0]  lit;   // digit expected lit in this frame
    logic [27:0] seg;   // {d3,d2,d1,d0} active-low segment patterns
    logic [3:0]  dpo;   // expected dp_out per digit when lit
  } fexp_t;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
    fexp_t       fe;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0, blank_in = 4'h0, blink_in = 4'h0;
  logic        load = 1'b0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  int n_vec = 0;
  int n_err = 0;
  int k = 0;   // edges since reset was last sampled; state index = k mod 16

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .BLINK_DIV(2)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
    .blink_in(blink_in), .load(load), .seg_out(seg_out), .dp_out(dp_out),
    .an_out(an_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                     input logic e_dp, input logic e_ft);
    n_vec++;
    if (an_out !== e_an || seg_out !== e_seg || dp_out !== e_dp || frame_tick !== e_ft) begin
      n_err++;
      $display("FAIL %s k=%0d: got an=%b seg=%b dp=%b ft=%b, expected an=%b seg=%b dp=%b ft=%b",
               name, k, an_out, seg_out, dp_out, frame_tick, e_an, e_seg, e_dp, e_ft);
    end
  endtask

  task automatic step(input string name, input fexp_t fe);
    int s, slot, dv;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    @(posedge clk);
    #1;
    k++;
    s = (k - 1) % 16;
    slot = s / 4;
    dv = s % 4;
    e_an = 4'hF;
    e_seg = 7'h7F;
    e_dp = 1'b1;
    if (dv != 0 && fe.lit[slot]) begin
      e_an = ~(4'b0001 << slot);
      e_seg = fe.seg[slot*7 +: 7];
      e_dp = fe.dpo[slot];
    end
    cmp(name, e_an, e_seg, e_dp, (k % 16 == 0));
  endtask

  task automatic run_until(input string name, input int p, input fexp_t fe);
    do step(name, fe); while (k % 16 != p);
  endtask

  task automatic do_load(input string name, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl, input logic [3:0] bk, input fexp_t fe);
    digits_in = d;
    dp_in = dp;
    blank_in = bl;
    blink_in = bk;
    load = 1'b1;
    step(name, fe);
    load = 1'b0;
  endtask

  task automatic reset_edge();
    rst = 1'b1;
    @(posedge clk);
    #1;
    k = 0;
    cmp("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  vec_t  vecs [4];
  fexp_t dark, cur, all2, wrapv, b0, b1;

  initial begin
    dark  = '{lit: 4'b0000, seg: 28'h0, dpo: 4'hF};
    vecs[0] = '{dig: 16'h1A30, dp: 4'b0100, blank: 4'b0000, blink: 4'b0000,
                fe: '{lit: 4'b1111, seg: {7'h79, 7'h08, 7'h30, 7'h40}, dpo: 4'b1011}};
    vecs[1] = '{dig: 16'h4567, dp: 4'b1001, blank: 4'b0010, blink: 4'b0000,
                fe: '{lit: 4'b1101, seg: {7'h19, 7'h12, 7'h02, 7'h78}, dpo: 4'b0110}};
    vecs[2] = '{dig: 16'h89BC, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000,
                fe: '{lit: 4'b1111, seg: {7'h00, 7'h10, 7'h03, 7'h46}, dpo: 4'b1111}};
    vecs[3] = '{dig: 16'hDEF0, dp: 4'b1111, blank: 4'b0000, blink: 4'b0000,
                fe: '{lit: 4'b1111, seg: {7'h21, 7'h06, 7'h0E, 7'h40}, dpo: 4'b0000}};
    all2  = '{lit: 4'b1111, seg: {4{7'h24}}, dpo: 4'b1111};
    wrapv = '{lit: 4'b1111, seg: {7'h78, 7'h0E, 7'h40, 7'h12}, dpo: 4'b1101};
    b0    = '{lit: 4'b1111, seg: {7'h40, 7'h40, 7'h40, 7'h00}, dpo: 4'b1111};
    b1    = '{lit: 4'b1110, seg: {7'h40, 7'h40, 7'h40, 7'h00}, dpo: 4'b1111};

    // Power-up reset, then two dark frames with a tick every 16 cycles.
    repeat (2) @(posedge clk);
    reset_edge();
    rst = 1'b0;
    run_until("idle_dark", 0, dark);
    run_until("idle_dark", 0, dark);

    // Table: load mid-frame, old value holds to the boundary, new value for a full frame.
    cur = dark;
    for (int i = 0; i < 4; i++) begin
      run_until("vec_hold", 5, cur);
      do_load("vec_hold", vecs[i].dig, vecs[i].dp, vecs[i].blank, vecs[i].blink, cur);
      run_until("vec_hold", 0, cur);
      run_until("vec_show", 0, vecs[i].fe);
      cur = vecs[i].fe;
    end

    // Two loads in one frame: only the last becomes visible, once, at the boundary.
    run_until("two_load", 3, cur);
    do_load("two_load", 16'h1111, 4'h0, 4'h0, 4'h0, cur);
    run_until("two_load", 9, cur);
    do_load("two_load", 16'h2222, 4'h0, 4'h0, 4'h0, cur);
    run_until("two_load", 0, cur);
    run_until("two_show", 0, all2);

    // Load on the wrap cycle shows in the very next frame and stays.
    run_until("wrap_load", 15, all2);
    do_load("wrap_load", 16'h7F05, 4'b0010, 4'h0, 4'h0, all2);
    run_until("wrap_show", 0, wrapv);
    run_until("wrap_show", 0, wrapv);

    // Reset mid-frame with a load pending: display returns dark and the load is lost.
    run_until("rst_pend", 5, wrapv);
    do_load("rst_pend", 16'h3333, 4'h0, 4'h0, 4'h0, wrapv);
    run_until("rst_pend", 9, wrapv);
    reset_edge();
    rst = 1'b0;
    run_until("rst_dark", 0, dark);
    run_until("rst_dark", 0, dark);

    // Blink: frames 2-3 after reset are phase 1, 4-5 phase 0, 6-7 phase 1.
    run_until("blink_ld", 5, dark);
    do_load("blink_ld", 16'h0008, 4'h0, 4'h0, 4'b0001, dark);
    run_until("blink_ld", 0, dark);
    run_until("blink_off", 0, b1);
    run_until("blink_on", 0, b0);
    run_until("blink_on", 0, b0);
    run_until("blink_off", 0, b1);
    run_until("blink_off", 0, b1);
    run_until("blink_on", 0, b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
